channel_scanner: RTL and testbench

Parametrised, registered N-channel selector that merges the 4:1 multiplexer and the 2:4 one-hot decoder into one block, with an automatic round-robin scan mode. In manual mode it routes the channel chosen by `s`. In scan mode an internal dwell counter steps through all channels. On every cycle it presents the selected data word, the channel index and the matching one-hot enable, all coherent with each other. It sits between multi-channel inputs (switches, sensors, display digits) and single-channel consumers such as display drivers and serial shifters.

---
 rtl/channel_scanner_if.sv | 30 +++
 rtl/channel_scanner.sv | 115 +++++++++++
 tb/tb_channel_scanner.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_scanner_if.sv
// Bus bundle for channel_scanner: channel data and control in,
// registered selection (data, index, one-hot, flags) out.
interface channel_scanner_if #(
    parameter int CH = 4,
    parameter int W  = 1
);
    localparam int SW = $clog2(CH);

    logic [CH*W-1:0] x;
    logic [SW-1:0]   s;
    logic            mode;
    logic            en;
    logic [W-1:0]    y;
    logic [SW-1:0]   sel;
    logic [CH-1:0]   onehot;
    logic            valid;
    logic            wrap;

    // Producer side: drives channel data and control, observes the selection
    modport master (
        output x, s, mode, en,
        input  y, sel, onehot, valid, wrap
    );

    // Scanner side
    modport slave (
        input  x, s, mode, en,
        output y, sel, onehot, valid, wrap
    );
endinterface

// File: rtl/channel_scanner.sv
// channel_scanner: registered N-channel selector with manual and
// round-robin scan modes. Mux and one-hot decode are merged: each lane
// compares the next index against its own number, and the lane hits form
// the one-hot while the masked lane data OR together into the output word.

// One lane: decodes its own hit and gates its data word onto the OR tree.
module channel_scanner_lane #(
    parameter int W   = 1,
    parameter int SW  = 2,
    parameter int IDX = 0
) (
    input  logic [SW-1:0] nsel,
    input  logic [W-1:0]  xd,
    output logic          hit,
    output logic [W-1:0]  md
);
    assign hit = (nsel == SW'(IDX));
    assign md  = hit ? xd : '0;
endmodule

module channel_scanner #(
    parameter  int CH    = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(CH),
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    channel_scanner_if.slave  bus
);
    logic [SW-1:0]         sel_q;
    logic [CW-1:0]         cnt_q;
    logic [W-1:0]          y_q;
    logic [CH-1:0]         onehot_q;
    logic                  valid_q;
    logic                  wrap_q;

    logic [SW-1:0]         nxt_sel;
    logic [CW-1:0]         nxt_cnt;
    logic                  nxt_wrap;

    logic [CH-1:0]         lane_hit;
    logic [CH-1:0][W-1:0]  lane_md;
    logic [W-1:0]          y_nxt;

    // Next channel: manual follows s; scan steps after DWELL enabled cycles.
    // CH is a power of two, so the SW-bit increment wraps CH-1 -> 0 for free.
    always_comb begin
        nxt_sel  = sel_q;
        nxt_cnt  = cnt_q;
        nxt_wrap = 1'b0;
        if (!bus.mode) begin
            nxt_sel = bus.s;
            nxt_cnt = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
            nxt_sel  = sel_q + SW'(1);
            nxt_cnt  = '0;
            nxt_wrap = (sel_q == SW'(CH - 1));
        end else begin
            nxt_cnt = cnt_q + CW'(1);
        end
    end

    // Per-channel decode/gate, evaluated on the index about to be registered
    // so data, index and one-hot always land together.
    for (genvar k = 0; k < CH; k++) begin : g_lane
        channel_scanner_lane #(
            .W   (W),
            .SW  (SW),
            .IDX (k)
        ) u_lane (
            .nsel (nxt_sel),
            .xd   (bus.x[k*W +: W]),
            .hit  (lane_hit[k]),
            .md   (lane_md[k])
        );
    end

    // OR-reduce the gated lanes; exactly one lane is non-masked.
    always_comb begin
        y_nxt = '0;
        for (int k = 0; k < CH; k++) y_nxt = y_nxt | lane_md[k];
    end

    // State and output registers; disabled cycles freeze sel/cnt/y and
    // drop the qualifiers so consumers see no stale channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else if (bus.en) begin
            sel_q    <= nxt_sel;
            cnt_q    <= nxt_cnt;
            y_q      <= y_nxt;
            onehot_q <= lane_hit;
            valid_q  <= 1'b1;
            wrap_q   <= nxt_wrap;
        end else begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end
    end

    assign bus.y      = y_q;
    assign bus.sel    = sel_q;
    assign bus.onehot = onehot_q;
    assign bus.valid  = valid_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_channel_scanner.sv
// Bench for channel_scanner: a CH=4/W=1/DWELL=3 instance checked against an
// arithmetic model (channel = anchor + enabled scan cycles / DWELL), plus a
// CH=8/W=4/DWELL=1 instance checked with closed-form expectations.
module tb_channel_scanner;
    localparam int DA = 3;

    logic clk;
    logic rst_a, rst_b;
    int   asserts  = 0;
    int   failures = 0;

    channel_scanner_if #(.CH(4), .W(1)) ba ();
    channel_scanner_if #(.CH(8), .W(4)) bb ();

    channel_scanner #(.CH(4), .W(1), .DWELL(DA)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ba.slave)
    );

    channel_scanner #(.CH(8), .W(4), .DWELL(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for instance A
    int   ma_anchor, ma_k, ma_sel;
    logic ma_y;
    bit   ma_valid, ma_wrap;

    function automatic logic [8:0] exp_a();
        logic [3:0] oh;
        oh = ma_valid ? (4'b0001 << ma_sel) : 4'b0000;
        return {ma_y, 2'(ma_sel), oh, ma_valid, ma_wrap};
    endfunction

    function automatic logic [8:0] obs_a();
        return {ba.y, ba.sel, ba.onehot, ba.valid, ba.wrap};
    endfunction

    function automatic logic [16:0] obs_b();
        return {bb.y, bb.sel, bb.onehot, bb.valid, bb.wrap};
    endfunction

    // Drive A for one clock and advance the model; returns #1 after the edge.
    task automatic step_a(input bit r, input bit e, input bit m,
                          input logic [1:0] s, input logic [3:0] x);
        int nsel;
        rst_a = r; ba.en = e; ba.mode = m; ba.s = s; ba.x = x;
        @(posedge clk);
        if (r) begin
            ma_anchor = 0; ma_k = 0; ma_sel = 0; ma_y = 1'b0;
            ma_valid = 0; ma_wrap = 0;
        end else if (!e) begin
            ma_valid = 0; ma_wrap = 0;
        end else if (!m) begin
            ma_anchor = int'(s); ma_k = 0; ma_sel = int'(s);
            ma_y = x[s]; ma_valid = 1; ma_wrap = 0;
        end else begin
            ma_k++;
            nsel = (ma_anchor + ma_k / DA) % 4;
            ma_wrap  = (ma_k % DA == 0) && (nsel == 0);
            ma_sel   = nsel;
            ma_y     = x[nsel];
            ma_valid = 1;
        end
        #1;
    endtask

    task automatic step_b(input bit r, input bit e, input bit m,
                          input logic [2:0] s, input logic [31:0] x);
        rst_b = r; bb.en = e; bb.mode = m; bb.s = s; bb.x = x;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_a(1, 1, 1, 2'd0, 4'hF);
        asserts++;
        if (obs_a() !== 9'b0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", obs_a(), 9'b0);
        end
        step_a(0, 0, 0, 2'd2, 4'hF);
        asserts++;
        if (obs_a() !== 9'b0 || exp_a() !== 9'b0) begin
            failures++;
            $display("FAIL idle_before_en: got %b expected %b", obs_a(), 9'b0);
        end
    endtask

    task automatic test_manual();
        logic [3:0] xv;
        logic [8:0] lit;
        xv = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step_a(0, 1, 0, 2'(i), xv);
            lit = {xv[i], 2'(i), 4'(4'b0001 << i), 1'b1, 1'b0};
            asserts++;
            if (obs_a() !== lit || obs_a() !== exp_a()) begin
                failures++;
                $display("FAIL manual_s%0d: got %b expected %b", i, obs_a(), lit);
            end
        end
    endtask

    task automatic test_scan_sweep();
        logic [3:0] xr;
        int         se;
        step_a(1, 0, 0, 2'd0, 4'h0);
        for (int i = 1; i <= 4 * DA; i++) begin
            xr = 4'($urandom);
            step_a(0, 1, 1, 2'($urandom), xr);
            se = (i / DA) % 4;
            asserts++;
            if (obs_a() !== exp_a() || ba.sel !== 2'(se) || ba.y !== xr[se]
                || ba.wrap !== (i == 4 * DA)) begin
                failures++;
                $display("FAIL scan_sweep cyc%0d: got %b expected %b", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_enable_gating();
        logic hold_y;
        step_a(1, 0, 0, 2'd0, 4'h0);
        for (int i = 0; i < 2 * DA + 1; i++) step_a(0, 1, 1, 2'd0, 4'($urandom));
        hold_y = ba.y;
        asserts++;
        if (ba.sel !== 2'd2 || obs_a() !== exp_a()) begin
            failures++;
            $display("FAIL gate_setup: got sel %0d expected 2", ba.sel);
        end
        for (int i = 0; i < 5; i++) begin
            step_a(0, 0, 1, 2'd0, 4'($urandom));
            asserts++;
            if ({ba.sel, ba.y, ba.onehot, ba.valid, ba.wrap} !== {2'd2, hold_y, 4'b0, 1'b0, 1'b0}
                || obs_a() !== exp_a()) begin
                failures++;
                $display("FAIL gate_hold%0d: got %b expected sel2 y%b oh0 v0", i, obs_a(), hold_y);
            end
        end
        step_a(0, 1, 1, 2'd0, 4'($urandom));
        asserts++;
        if (ba.sel !== 2'd2 || ba.onehot !== 4'b0100 || obs_a() !== exp_a()) begin
            failures++;
            $display("FAIL gate_resume1: got %b expected sel 2", obs_a());
        end
        step_a(0, 1, 1, 2'd0, 4'($urandom));
        asserts++;
        if (ba.sel !== 2'd3 || ba.onehot !== 4'b1000 || obs_a() !== exp_a()) begin
            failures++;
            $display("FAIL gate_resume2: got %b expected sel 3", obs_a());
        end
    endtask

    task automatic test_mode_switch();
        step_a(1, 0, 0, 2'd0, 4'h0);
        for (int i = 0; i < DA; i++) step_a(0, 1, 1, 2'd0, 4'($urandom));
        step_a(0, 1, 0, 2'd3, 4'b1000);
        asserts++;
        if (ba.sel !== 2'd3 || ba.onehot !== 4'b1000 || ba.y !== 1'b1 || obs_a() !== exp_a()) begin
            failures++;
            $display("FAIL mode_to_manual: got %b expected sel3 oh1000", obs_a());
        end
        for (int i = 1; i <= DA; i++) begin
            step_a(0, 1, 1, 2'd1, 4'($urandom));
            asserts++;
            if (ba.sel !== ((i == DA) ? 2'd0 : 2'd3) || ba.wrap !== (i == DA)
                || obs_a() !== exp_a()) begin
                failures++;
                $display("FAIL mode_to_scan%0d: got %b expected %b", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_reset_mid();
        step_a(1, 0, 0, 2'd0, 4'h0);
        for (int i = 0; i < 3 * DA; i++) step_a(0, 1, 1, 2'd0, 4'($urandom));
        step_a(1, 1, 1, 2'd0, 4'hF);
        asserts++;
        if (obs_a() !== 9'b0) begin
            failures++;
            $display("FAIL reset_mid: got %b expected %b", obs_a(), 9'b0);
        end
        for (int i = 1; i <= DA; i++) begin
            step_a(0, 1, 1, 2'd0, 4'($urandom));
            asserts++;
            if (ba.sel !== ((i == DA) ? 2'd1 : 2'd0) || obs_a() !== exp_a()) begin
                failures++;
                $display("FAIL reset_restart%0d: got %b expected %b", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_random();
        bit r, e, m;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 2) != 0);
            step_a(r, e, m, 2'($urandom), 4'($urandom));
            asserts++;
            if (obs_a() !== exp_a()) begin
                failures++;
                $display("FAIL random cyc%0d: got %b expected %b", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_wide();
        logic [31:0] xv;
        logic [16:0] lit;
        int          se;
        for (int k = 0; k < 8; k++) xv[k*4 +: 4] = 4'(k);
        step_b(1, 0, 0, 3'd0, xv);
        asserts++;
        if (obs_b() !== 17'b0) begin
            failures++;
            $display("FAIL wide_reset: got %h expected 0", obs_b());
        end
        for (int i = 1; i <= 34; i++) begin
            if (i > 17) xv = $urandom;
            step_b(0, 1, 1, 3'($urandom), xv);
            se  = i % 8;
            lit = {xv[se*4 +: 4], 3'(se), 8'(8'b1 << se), 1'b1, (se == 0)};
            asserts++;
            if (obs_b() !== lit) begin
                failures++;
                $display("FAIL wide_scan cyc%0d: got %h expected %h", i, obs_b(), lit);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ba.en = 1'b0; ba.mode = 1'b0; ba.s = '0; ba.x = '0;
        bb.en = 1'b0; bb.mode = 1'b0; bb.s = '0; bb.x = '0;
        test_reset();
        test_manual();
        test_scan_sweep();
        test_enable_gating();
        test_mode_switch();
        test_reset_mid();
        test_random();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
